// File: rtl/isqrt_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_stage_pipe
// Description : Fully pipelined unsigned integer square root, y = floor(sqrt(x)).
//               Restoring digit-by-digit algorithm (16 root bits), split into
//               16/ITERS_PER_STAGE registered stages. One argument per clock,
//               no backpressure, results leave in issue order after exactly
//               16/ITERS_PER_STAGE cycles.
// Ports       : clk    - clock, rising edge
//               rst    - synchronous reset, active-high
//               x_vld  - x carries a valid argument this cycle
//               x      - 32-bit unsigned radicand
//               y_vld  - y carries a valid result this cycle
//               y      - 16-bit root of the argument issued N cycles earlier
// Revision    : 1.0 - initial release
// ============================================================================
module isqrt_stage_pipe #(
    parameter int ITERS_PER_STAGE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_vld,
    input  logic [31:0] x,
    output logic        y_vld,
    output logic [15:0] y
);

    // Guard against division by zero so the illegal-parameter message below
    // is the only thing reported for a bad value.
    localparam int STAGES = (ITERS_PER_STAGE > 0) ? (16 / ITERS_PER_STAGE) : 1;

    if (!(ITERS_PER_STAGE == 1 || ITERS_PER_STAGE == 2 || ITERS_PER_STAGE == 4 ||
          ITERS_PER_STAGE == 8 || ITERS_PER_STAGE == 16)) begin : g_bad_param
        $error("isqrt_stage_pipe: ITERS_PER_STAGE must be 1, 2, 4, 8 or 16");
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic        v_in;
        logic [17:0] rem_in;
        logic [15:0] root_in;
        logic [31:0] xs_in;      // unconsumed radicand pairs, next pair in [31:30]

        logic [17:0] rem_d;
        logic [15:0] root_d;
        logic [31:0] xs_d;
        logic [18:0] trial;      // signed trial subtraction, sign in bit 18

        logic        v_q;
        logic [15:0] root_q;

        if (s == 0) begin : g_src
            assign v_in    = x_vld;
            assign rem_in  = '0;
            assign root_in = '0;
            assign xs_in   = x;
        end else begin : g_src
            assign v_in    = g_stage[s-1].v_q;
            assign rem_in  = g_stage[s-1].g_carry.rem_q;
            assign root_in = g_stage[s-1].root_q;
            assign xs_in   = g_stage[s-1].g_carry.xs_q;
        end

        // Since rem <= 2*root, {rem, pair} < 2^19, so a 19-bit difference
        // holds both the result and a reliable sign bit.
        always_comb begin
            rem_d  = rem_in;
            root_d = root_in;
            xs_d   = xs_in;
            trial  = '0;
            for (int k = 0; k < ITERS_PER_STAGE; k++) begin
                trial = 19'({rem_d, xs_d[31:30]}) - 19'({root_d, 2'b01});
                if (!trial[18]) begin
                    rem_d  = trial[17:0];
                    root_d = {root_d[14:0], 1'b1};
                end else begin
                    rem_d  = {rem_d[15:0], xs_d[31:30]};
                    root_d = {root_d[14:0], 1'b0};
                end
                xs_d = {xs_d[29:0], 2'b00};
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q    <= 1'b0;
                root_q <= '0;
            end else begin
                v_q    <= v_in;
                root_q <= root_d;
            end
        end

        // The final stage's remainder and leftover radicand are never needed,
        // so only intermediate stages carry them forward.
        if (s < STAGES - 1) begin : g_carry
            logic [17:0] rem_q;
            logic [31:0] xs_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rem_q <= '0;
                    xs_q  <= '0;
                end else begin
                    rem_q <= rem_d;
                    xs_q  <= xs_d;
                end
            end
        end
    end

    assign y_vld = g_stage[STAGES-1].v_q;
    assign y     = g_stage[STAGES-1].root_q;

endmodule
`default_nettype wire
